// File: rtl/instruction_sequencer.sv
// instruction_sequencer: accepts host instructions, issues write strobes and streams
// an inclusive range of read addresses under downstream backpressure.
module instruction_sequencer #(
    parameter  int FIELD_W = 15,
    localparam int INSTR_W = 2 + 2 * FIELD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic               wr_en,
    output logic [FIELD_W-1:0] wr_addr,
    output logic [FIELD_W-1:0] wr_data,
    output logic [FIELD_W-1:0] rd_start_addr,
    output logic [FIELD_W-1:0] rd_end_addr,
    output logic               rd_en,
    output logic [FIELD_W-1:0] rd_addr,
    input  logic               rd_ready,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
    localparam logic [1:0] OP_WRITE = 2'b01, OP_RANGE = 2'b10, OP_GO = 2'b11;
    state_t state_q, state_d;
    logic wr_en_q, wr_en_d, cfg_err_q, cfg_err_d;
    logic [FIELD_W-1:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic [FIELD_W-1:0] start_q, start_d, end_q, end_d, rd_addr_q, rd_addr_d;
    logic [1:0] op;
    logic [FIELD_W-1:0] fa, fb;
    logic accept;
    assign op     = instr[INSTR_W-1 -: 2];
    assign fa     = instr[2*FIELD_W-1:FIELD_W];
    assign fb     = instr[FIELD_W-1:0];
    assign accept = instr_valid && instr_ready;
    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        start_d   = start_q;
        end_d     = end_q;
        rd_addr_d = rd_addr_q;
        cfg_err_d = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                if (op == OP_WRITE) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = fa;
                    wr_data_d = fb;
                end
                if (op == OP_RANGE) begin
                    start_d = fa;
                    end_d   = fb;
                end
                if (op == OP_GO) begin
                    cfg_err_d = start_q > end_q;
                    state_d   = start_q > end_q ? IDLE : STREAM;
                    rd_addr_d = start_q > end_q ? rd_addr_q : start_q;
                end
            end
            // Stopping at the end address means the increment can never wrap.
            STREAM: if (rd_ready) begin
                state_d   = rd_addr_q == end_q ? DONE : STREAM;
                rd_addr_d = rd_addr_q == end_q ? rd_addr_q : rd_addr_q + FIELD_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            start_q   <= '0;
            end_q     <= '0;
            rd_addr_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            end_q     <= end_d;
            rd_addr_q <= rd_addr_d;
            cfg_err_q <= cfg_err_d;
        end
    end
    assign instr_ready   = state_q == IDLE;
    assign rd_en         = state_q == STREAM;
    assign busy          = state_q == STREAM;
    assign done          = state_q == DONE;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign rd_start_addr = start_q;
    assign rd_end_addr   = end_q;
    assign rd_addr       = rd_addr_q;
    assign cfg_err       = cfg_err_q;
endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed and random instruction streams checked against a
// transaction-level model of writes, range registers and inclusive read streams.
module tb_instruction_sequencer;
    localparam int FW = 15;
    localparam int IW = 2 + 2 * FW;
    logic clk = 1'b0, rst_n = 1'b0;
    logic [IW-1:0] instr = '0;
    logic instr_valid = 1'b0, rd_ready = 1'b0;
    logic instr_ready, wr_en, rd_en, busy, done, cfg_err;
    logic [FW-1:0] wr_addr, wr_data, rd_start_addr, rd_end_addr, rd_addr;
    int n_cmp = 0, n_err = 0;
    int m_start = 0, m_end = 0, m_wa = 0, m_wd = 0;
    int rdy_mode = 0;
    int pat[$];

    instruction_sequencer #(.FIELD_W(FW)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_start_addr(rd_start_addr), .rd_end_addr(rd_end_addr), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_ready(rd_ready), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected reads are simply start, start+1, ..., end, one per accepted handshake.
    task automatic stream();
        int exp_a = m_start;
        int n_hs = 0, cyc = 0, pi = 0;
        int bound = (m_end - m_start + 1) * 8 + 64;
        bit fin = 0;
        bit r;
        while (!fin) begin
            chk("st_rd_en", rd_en, 1);
            chk("st_busy", busy, 1);
            chk("st_ready", instr_ready, 0);
            chk("st_addr", rd_addr, exp_a);
            if (cyc > 0) chk("st_wr_en", wr_en, 0);
            r = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? (pi < pat.size() ? pat[pi] != 0 : 1'b1) : 1'($urandom_range(0, 1));
            pi++;
            rd_ready = r;
            instr_valid = 1'($urandom_range(0, 1));
            instr = IW'($urandom);
            @(negedge clk);
            cyc++;
            if (r) begin
                n_hs++;
                if (exp_a == m_end) fin = 1;
                else exp_a++;
            end
            if (!fin && cyc > bound) begin
                chk("st_timeout", 1, 0);
                fin = 1;
            end
        end
        instr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("st_count", n_hs, m_end - m_start + 1);
        chk("dn_done", done, 1);
        chk("dn_busy", busy, 0);
        chk("dn_rd_en", rd_en, 0);
        chk("dn_ready", instr_ready, 0);
        chk("dn_wr_addr", wr_addr, m_wa);
        chk("dn_range", {1'b0, rd_start_addr, 1'b0, rd_end_addr}, {16'(m_start), 16'(m_end)});
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_ready", instr_ready, 1);
    endtask

    task automatic send(input logic [1:0] op, input logic [FW-1:0] a, input logic [FW-1:0] b);
        bit bad;
        chk("snd_ready", instr_ready, 1);
        instr = {op, a, b};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        bad = op == 2'b11 && m_start > m_end;
        if (op == 2'b01) begin m_wa = a; m_wd = b; end
        if (op == 2'b10) begin m_start = a; m_end = b; end
        chk("wr_en", wr_en, op == 2'b01);
        chk("wr_addr", wr_addr, m_wa);
        chk("wr_data", wr_data, m_wd);
        chk("rd_start", rd_start_addr, m_start);
        chk("rd_end", rd_end_addr, m_end);
        chk("cfg_err", cfg_err, bad);
        chk("rd_en", rd_en, op == 2'b11 && !bad);
        if (op == 2'b11 && !bad) stream();
        if (bad) begin
            chk("err_busy", busy, 0);
            chk("err_ready", instr_ready, 1);
            @(negedge clk);
            chk("err_clear", cfg_err, 0);
            chk("err_rd_en", rd_en, 0);
            chk("err_busy2", busy, 0);
        end
    endtask

    initial begin
        int s, e;
        repeat (2) @(negedge clk);
        chk("rst_outs", {wr_en, rd_en, busy, done, cfg_err}, 0);
        chk("rst_regs", {wr_addr, wr_data, rd_start_addr, rd_end_addr, rd_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_idle", instr_ready, 1);
        send(2'b01, 15'h1084, 15'h211C);
        send(2'b00, 15'h7FFF, 15'h7FFF);
        rdy_mode = 0;
        send(2'b10, 5, 8);
        send(2'b11, 0, 0);
        rdy_mode = 2;
        pat = '{1, 0, 0, 1, 1, 0, 1};
        send(2'b10, 5, 8);
        send(2'b11, 0, 0);
        rdy_mode = 0;
        send(2'b10, 9, 3);
        send(2'b11, 0, 0);
        send(2'b10, 7, 7);
        send(2'b11, 0, 0);
        send(2'b10, 15'h7FFE, 15'h7FFF);
        send(2'b11, 0, 0);
        // Reset asserted between edges while the stream sits at address 6.
        send(2'b10, 5, 8);
        instr = {2'b11, 30'h0};
        instr_valid = 1'b1;
        rd_ready = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ar_first", rd_addr, 5);
        for (int i = 0; i < 10 && rd_addr != 6; i++) @(negedge clk);
        chk("ar_at6", rd_addr, 6);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_drop", {rd_en, busy, wr_en, done}, 0);
        @(negedge clk);
        chk("ar_nodone", done, 0);
        rst_n = 1'b1;
        rd_ready = 1'b0;
        m_start = 0; m_end = 0; m_wa = 0; m_wd = 0;
        @(negedge clk);
        chk("ar_range", {rd_start_addr, rd_end_addr}, 0);
        chk("ar_state", {done, busy, instr_ready}, 1);
        rdy_mode = 1;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 4))
                0: send(2'b00, FW'($urandom), FW'($urandom));
                1: send(2'b01, FW'($urandom), FW'($urandom));
                2, 3: begin
                    s = $urandom_range(0, 32767);
                    e = s + $urandom_range(0, 15) - 3;
                    e = e < 0 ? 0 : e > 32767 ? 32767 : e;
                    send(2'b10, FW'(s), FW'(e));
                end
                default: send(2'b11, FW'($urandom), FW'($urandom));
            endcase
        end
        rdy_mode = 0;
        send(2'b10, 0, 15'h7FFF);
        send(2'b11, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
